pipelined_instr_decoder: RTL

Registered MIPS-32 decode stage that sits between instruction fetch and the control/execute logic of the CPU.
- Turns each fetched instruction into a one-hot operation code plus extracted register and immediate fields.
- Flags illegal encodings and keeps a saturating count of them.
- Uses valid/ready handshakes on both sides, a one-entry skid buffer, a flush input and a build-time switch that adds the extended instruction set.

---
 rtl/pipelined_instr_decoder_pkg.sv | 42 ++++
 rtl/pipelined_instr_decoder_if.sv | 36 +++
 rtl/pipelined_instr_decode_comb.sv | 96 +++++++++
 rtl/pipelined_instr_decoder.sv | 115 +++++++++++
 4 files changed

// File: rtl/pipelined_instr_decoder_pkg.sv
// rtl/pipelined_instr_decoder_pkg.sv - MIPS-32 opcode/funct encodings and one-hot operation indices
package pipelined_instr_decoder_pkg;

    localparam int CODE_W_BASE = 31;
    localparam int CODE_W_EXT  = 55;

    // One-hot bit positions shared with the control unit
    localparam int OP_ADD  = 0,  OP_ADDU = 1,  OP_SUB   = 2,  OP_SUBU  = 3,  OP_AND  = 4;
    localparam int OP_OR   = 5,  OP_XOR  = 6,  OP_NOR   = 7,  OP_SLT   = 8,  OP_SLTU = 9;
    localparam int OP_SLL  = 10, OP_SRL  = 11, OP_SRA   = 12, OP_SLLV  = 13, OP_SRLV = 14;
    localparam int OP_SRAV = 15, OP_JR   = 16, OP_ADDI  = 17, OP_ADDIU = 18, OP_ANDI = 19;
    localparam int OP_ORI  = 20, OP_XORI = 21, OP_LUI   = 22, OP_LW    = 23, OP_SW   = 24;
    localparam int OP_BEQ  = 25, OP_BNE  = 26, OP_SLTI  = 27, OP_SLTIU = 28, OP_J    = 29;
    localparam int OP_JAL  = 30, OP_JALR = 31, OP_MULT  = 32, OP_MULTU = 33, OP_DIV  = 34;
    localparam int OP_DIVU = 35, OP_MFHI = 36, OP_MFLO  = 37, OP_MTHI  = 38, OP_MTLO = 39;
    localparam int OP_SYSCALL = 40, OP_BREAK = 41, OP_TEQ = 42, OP_LB = 43, OP_LBU = 44;
    localparam int OP_LH   = 45, OP_LHU  = 46, OP_SB    = 47, OP_SH    = 48, OP_BGEZ = 49;
    localparam int OP_CLZ  = 50, OP_MUL  = 51, OP_ERET  = 52, OP_MFC0  = 53, OP_MTC0 = 54;

    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08, OPC_ADDIU  = 6'h09, OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B, OPC_ANDI   = 6'h0C, OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E, OPC_LUI    = 6'h0F, OPC_COP0  = 6'h10;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C, OPC_LB    = 6'h20, OPC_LH    = 6'h21;
    localparam logic [5:0] OPC_LW      = 6'h23, OPC_LBU    = 6'h24, OPC_LHU   = 6'h25;
    localparam logic [5:0] OPC_SB      = 6'h28, OPC_SH     = 6'h29, OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D, FN_MFHI = 6'h10, FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV  = 6'h1A, FN_DIVU = 6'h1B, FN_ADD   = 6'h20, FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_TEQ  = 6'h34;
    localparam logic [5:0] FN2_CLZ = 6'h20, FN2_MUL = 6'h02, FN_ERET  = 6'h18;

    localparam logic [4:0] RT_BGEZ = 5'b00001;
    localparam logic [4:0] RS_ERET = 5'b10000, RS_MFC0 = 5'b00000, RS_MTC0 = 5'b00100;

endpackage

// File: rtl/pipelined_instr_decoder_if.sv
// rtl/pipelined_instr_decoder_if.sv - fetch-side and consumer-side handshake bundle of the decode stage
interface pipelined_instr_decoder_if #(
    parameter bit EXT_EN = 1'b1,
    parameter int PC_W   = 32
);
    import pipelined_instr_decoder_pkg::*;
    localparam int CODE_W = EXT_EN ? CODE_W_EXT : CODE_W_BASE;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_illegal;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [15:0]       out_imm;
    logic [25:0]       out_target;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_code, out_illegal, out_rs, out_rt, out_rd,
               out_shamt, out_imm, out_target, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_code, out_illegal, out_rs, out_rt, out_rd,
               out_shamt, out_imm, out_target, out_pc
    );
endinterface

// File: rtl/pipelined_instr_decode_comb.sv
// rtl/pipelined_instr_decode_comb.sv - combinational instruction field to one-hot op-code decode
module instr_decode_comb
    import pipelined_instr_decoder_pkg::*;
#(
    parameter bit EXT_EN = 1'b1,
    parameter int CODE_W = CODE_W_EXT
) (
    input  logic [5:0]        i_op,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [5:0]        i_fn,
    output logic [CODE_W-1:0] o_code,
    output logic              o_illegal
);

    logic [CODE_W_EXT-1:0] w_all;

    always_comb begin
        w_all = '0;
        case (i_op)
            OPC_SPECIAL: begin
                case (i_fn)
                    FN_ADD:     w_all[OP_ADD]     = 1'b1;
                    FN_ADDU:    w_all[OP_ADDU]    = 1'b1;
                    FN_SUB:     w_all[OP_SUB]     = 1'b1;
                    FN_SUBU:    w_all[OP_SUBU]    = 1'b1;
                    FN_AND:     w_all[OP_AND]     = 1'b1;
                    FN_OR:      w_all[OP_OR]      = 1'b1;
                    FN_XOR:     w_all[OP_XOR]     = 1'b1;
                    FN_NOR:     w_all[OP_NOR]     = 1'b1;
                    FN_SLT:     w_all[OP_SLT]     = 1'b1;
                    FN_SLTU:    w_all[OP_SLTU]    = 1'b1;
                    FN_SLL:     w_all[OP_SLL]     = 1'b1;
                    FN_SRL:     w_all[OP_SRL]     = 1'b1;
                    FN_SRA:     w_all[OP_SRA]     = 1'b1;
                    FN_SLLV:    w_all[OP_SLLV]    = 1'b1;
                    FN_SRLV:    w_all[OP_SRLV]    = 1'b1;
                    FN_SRAV:    w_all[OP_SRAV]    = 1'b1;
                    FN_JR:      w_all[OP_JR]      = 1'b1;
                    FN_JALR:    w_all[OP_JALR]    = 1'b1;
                    FN_MULT:    w_all[OP_MULT]    = 1'b1;
                    FN_MULTU:   w_all[OP_MULTU]   = 1'b1;
                    FN_DIV:     w_all[OP_DIV]     = 1'b1;
                    FN_DIVU:    w_all[OP_DIVU]    = 1'b1;
                    FN_MFHI:    w_all[OP_MFHI]    = 1'b1;
                    FN_MFLO:    w_all[OP_MFLO]    = 1'b1;
                    FN_MTHI:    w_all[OP_MTHI]    = 1'b1;
                    FN_MTLO:    w_all[OP_MTLO]    = 1'b1;
                    FN_SYSCALL: w_all[OP_SYSCALL] = 1'b1;
                    FN_BREAK:   w_all[OP_BREAK]   = 1'b1;
                    FN_TEQ:     w_all[OP_TEQ]     = 1'b1;
                    default:    w_all = '0;
                endcase
            end
            OPC_ADDI:  w_all[OP_ADDI]  = 1'b1;
            OPC_ADDIU: w_all[OP_ADDIU] = 1'b1;
            OPC_ANDI:  w_all[OP_ANDI]  = 1'b1;
            OPC_ORI:   w_all[OP_ORI]   = 1'b1;
            OPC_XORI:  w_all[OP_XORI]  = 1'b1;
            OPC_LUI:   w_all[OP_LUI]   = 1'b1;
            OPC_LW:    w_all[OP_LW]    = 1'b1;
            OPC_SW:    w_all[OP_SW]    = 1'b1;
            OPC_BEQ:   w_all[OP_BEQ]   = 1'b1;
            OPC_BNE:   w_all[OP_BNE]   = 1'b1;
            OPC_SLTI:  w_all[OP_SLTI]  = 1'b1;
            OPC_SLTIU: w_all[OP_SLTIU] = 1'b1;
            OPC_J:     w_all[OP_J]     = 1'b1;
            OPC_JAL:   w_all[OP_JAL]   = 1'b1;
            OPC_LB:    w_all[OP_LB]    = 1'b1;
            OPC_LBU:   w_all[OP_LBU]   = 1'b1;
            OPC_LH:    w_all[OP_LH]    = 1'b1;
            OPC_LHU:   w_all[OP_LHU]   = 1'b1;
            OPC_SB:    w_all[OP_SB]    = 1'b1;
            OPC_SH:    w_all[OP_SH]    = 1'b1;
            OPC_REGIMM: w_all[OP_BGEZ] = (i_rt == RT_BGEZ);
            OPC_SPECIAL2: begin
                w_all[OP_CLZ] = (i_fn == FN2_CLZ);
                w_all[OP_MUL] = (i_fn == FN2_MUL);
            end
            OPC_COP0: begin
                w_all[OP_ERET] = (i_rs == RS_ERET) && (i_fn == FN_ERET);
                w_all[OP_MFC0] = (i_rs == RS_MFC0);
                w_all[OP_MTC0] = (i_rs == RS_MTC0);
            end
            default: w_all = '0;
        endcase
        // Base-only builds treat every extended encoding as illegal
        if (!EXT_EN) begin
            w_all[CODE_W_EXT-1:CODE_W_BASE] = '0;
        end
    end

    assign o_code    = w_all[CODE_W-1:0];
    assign o_illegal = ~|w_all;

endmodule

// File: rtl/pipelined_instr_decoder.sv
// rtl/pipelined_instr_decoder.sv - registered decode stage with one-entry skid buffer and illegal counter
module pipelined_instr_decoder
    import pipelined_instr_decoder_pkg::*;
#(
    parameter bit EXT_EN    = 1'b1,
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    pipelined_instr_decoder_if.slave bus,
    output logic [ILL_CNT_W-1:0]     ill_count
);

    localparam int CODE_W = EXT_EN ? CODE_W_EXT : CODE_W_BASE;
    localparam logic [ILL_CNT_W-1:0] CNT_ONE = 1;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              illegal;
        logic [31:0]       instr;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t                w_new;
    entry_t                r_out;
    entry_t                r_skid;
    logic                  r_out_valid;
    logic                  r_skid_valid;
    logic                  r_in_ready;
    logic [ILL_CNT_W-1:0]  r_ill_count;
    logic [CODE_W-1:0]     w_dec_code;
    logic                  w_dec_illegal;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_out_load;

    instr_decode_comb #(
        .EXT_EN (EXT_EN),
        .CODE_W (CODE_W)
    ) u_decode (
        .i_op      (bus.in_instr[31:26]),
        .i_rs      (bus.in_instr[25:21]),
        .i_rt      (bus.in_instr[20:16]),
        .i_fn      (bus.in_instr[5:0]),
        .o_code    (w_dec_code),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        w_new         = '0;
        w_new.code    = w_dec_code;
        w_new.illegal = w_dec_illegal;
        w_new.instr   = bus.in_instr;
        w_new.pc      = bus.in_pc;
    end

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;
    assign w_out_load = ~r_out_valid | bus.out_ready;

    // in_ready mirrors "skid empty", so an accept never coincides with a full skid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out <= w_new;
                end
            end
        end else if (w_in_fire) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ill_count <= '0;
        end else if (w_out_fire && r_out.illegal && (r_ill_count != '1)) begin
            r_ill_count <= r_ill_count + CNT_ONE;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_code    = r_out.code;
    assign bus.out_illegal = r_out.illegal;
    assign bus.out_rs      = r_out.instr[25:21];
    assign bus.out_rt      = r_out.instr[20:16];
    assign bus.out_rd      = r_out.instr[15:11];
    assign bus.out_shamt   = r_out.instr[10:6];
    assign bus.out_imm     = r_out.instr[15:0];
    assign bus.out_target  = r_out.instr[25:0];
    assign bus.out_pc      = r_out.pc;
    assign ill_count       = r_ill_count;

endmodule
